// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA-256 UART wrapper: register map,
// status flag positions, block byte counts and the sequencer/phase encodings.
package rsa_pkg;
  localparam int RX_ADDR     = 0;
  localparam int TX_ADDR     = 4;
  localparam int STATUS_ADDR = 8;
  localparam int RX_RDY_BIT  = 7;
  localparam int TX_RDY_BIT  = 6;
  localparam int RX_BYTES    = 32;
  localparam int TX_BYTES    = 31;

  typedef enum logic [2:0] {
    S_QUERY_RX, S_READ, S_QUERY_TX, S_WRITE, S_CALC
  } state_t;

  typedef enum logic [1:0] {
    KEY_N, KEY_D, DATA
  } phase_t;
endpackage

// File: rtl/rsa256_wrapper_if.sv
// Avalon-MM master bundle between the wrapper and its UART byte sequencer.
interface rsa256_wrapper_if;
  logic [4:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, read, write, writedata,
                  input  readdata, waitrequest);
  modport slave  (input  address, read, write, writedata,
                  output readdata, waitrequest);
endinterface

// File: rtl/rsa256_wrapper_byte_io.sv
// Poll-then-transfer sequencer: status poll, one data byte moved over Avalon,
// and the compute wait between the last received byte and the first sent one.
module rsa_avm_byte_io
  import rsa_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  rsa256_wrapper_if.master bus,
  input  logic        i_rx_last,
  input  logic        i_tx_last,
  input  logic        i_calc_done,
  input  logic [7:0]  i_tx_byte,
  output state_t      o_state,
  output logic        o_rx_strobe,
  output logic        o_tx_strobe,
  output logic [7:0]  o_rx_byte
);
  state_t state, state_n;
  logic   gap;
  logic   req, done;
  logic   unused_rd;

  // gap forces one idle cycle after every completed transfer; it also keeps
  // the bus quiet while reset is held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_QUERY_RX;
      gap   <= 1'b1;
    end else begin
      state <= state_n;
      gap   <= done;
    end
  end

  assign req  = (state != S_CALC) && !gap;
  assign done = req && !bus.waitrequest;

  always_comb begin
    state_n = state;
    case (state)
      S_QUERY_RX: if (done && bus.readdata[RX_RDY_BIT]) state_n = S_READ;
      S_READ:     if (done) state_n = i_rx_last ? S_CALC : S_QUERY_RX;
      S_CALC:     if (i_calc_done) state_n = S_QUERY_TX;
      S_QUERY_TX: if (done && bus.readdata[TX_RDY_BIT]) state_n = S_WRITE;
      S_WRITE:    if (done) state_n = i_tx_last ? S_QUERY_RX : S_QUERY_TX;
      default:    state_n = S_QUERY_RX;
    endcase
  end

  always_comb begin
    bus.address   = 5'(STATUS_ADDR);
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    case (state)
      S_QUERY_RX, S_QUERY_TX: bus.read = !gap;
      S_READ: begin
        bus.address = 5'(RX_ADDR);
        bus.read    = !gap;
      end
      S_WRITE: begin
        bus.address   = 5'(TX_ADDR);
        bus.write     = !gap;
        bus.writedata = {24'd0, i_tx_byte};
      end
      default: ;
    endcase
  end

  assign o_state     = state;
  assign o_rx_strobe = (state == S_READ) && done;
  assign o_tx_strobe = (state == S_WRITE) && done;
  assign o_rx_byte   = bus.readdata[7:0];
  assign unused_rd   = ^bus.readdata[31:8];
endmodule

// File: rtl/rsa256_wrapper.sv
// RSA-256 UART front end: loads n, d and ciphertext blocks byte-serially,
// starts the external core, and streams the 31-byte plaintext back out.
module rsa256_wrapper
  import rsa_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  output logic         avm_write,
  input  logic [31:0]  avm_readdata,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [269:0] i_core_result,
  input  logic         i_core_finished
);
  rsa256_wrapper_if bus ();

  assign avm_address     = bus.address;
  assign avm_read        = bus.read;
  assign avm_write       = bus.write;
  assign avm_writedata   = bus.writedata;
  assign bus.readdata    = avm_readdata;
  assign bus.waitrequest = avm_waitrequest;

  state_t       state;
  phase_t       phase;
  logic [4:0]   rx_cnt, tx_cnt;
  logic [255:0] n_reg, d_reg, a_reg, out_reg;
  logic         start_q, fin_q;
  logic         rx_strobe, tx_strobe, rx_last, tx_last, calc_done;
  logic [7:0]   rx_byte;
  logic         unused_res;

  assign rx_last   = (phase == DATA) && (rx_cnt == 5'(RX_BYTES - 1));
  assign tx_last   = (tx_cnt == 5'(TX_BYTES - 1));
  // Only a fresh edge counts: a finished level left over from the previous
  // block must not release stale data.
  assign calc_done = (state == S_CALC) && i_core_finished && !fin_q;

  rsa_avm_byte_io u_io (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .i_rx_last   (rx_last),
    .i_tx_last   (tx_last),
    .i_calc_done (calc_done),
    .i_tx_byte   (out_reg[247:240]),
    .o_state     (state),
    .o_rx_strobe (rx_strobe),
    .o_tx_strobe (tx_strobe),
    .o_rx_byte   (rx_byte)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase   <= KEY_N;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
      n_reg   <= '0;
      d_reg   <= '0;
      a_reg   <= '0;
      out_reg <= '0;
      start_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      fin_q   <= i_core_finished;
      if (rx_strobe) begin
        case (phase)
          KEY_N:   n_reg <= {n_reg[247:0], rx_byte};
          KEY_D:   d_reg <= {d_reg[247:0], rx_byte};
          default: a_reg <= {a_reg[247:0], rx_byte};
        endcase
        rx_cnt <= rx_cnt + 5'd1;
        // Key stays loaded once in DATA; later blocks carry ciphertext only.
        if (rx_cnt == 5'(RX_BYTES - 1)) begin
          case (phase)
            KEY_N:   phase   <= KEY_D;
            KEY_D:   phase   <= DATA;
            default: start_q <= 1'b1;
          endcase
        end
      end
      if (calc_done) out_reg <= i_core_result[255:0];
      if (tx_strobe) begin
        out_reg <= out_reg << 8;
        tx_cnt  <= tx_last ? 5'd0 : tx_cnt + 5'd1;
      end
    end
  end

  assign o_core_start = start_q;
  assign o_core_a     = a_reg;
  assign o_core_d     = d_reg;
  assign o_core_n     = n_reg;
  assign unused_res   = ^i_core_result[269:256];
endmodule

// File: doc/rsa256_wrapper.md
RSA256_WRAPPER -- requirements
Module: rsa256_wrapper

Interface
REQ-001 SHALL have port i_clk, input, 1, the system clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port avm_address, output, 5, UART register byte address.
REQ-004 SHALL have ports avm_read and avm_write, output, 1 each, Avalon-MM read and write requests.
REQ-005 SHALL have port avm_readdata, input, 32, UART read data.
REQ-006 SHALL have port avm_writedata, output, 32, UART write data; bits 31:8 are 0.
REQ-007 SHALL have port avm_waitrequest, input, 1, Avalon-MM stall.
REQ-008 SHALL have port o_core_start, output, 1, one-cycle start pulse to the RSA core.
REQ-009 SHALL have ports o_core_a, o_core_d and o_core_n, output, 256 each: ciphertext, private key and modulus.
REQ-010 SHALL have port i_core_result, input, 270, core result; only bits 255:0 are used.
REQ-011 SHALL have port i_core_finished, input, 1, core done level.
REQ-012 SHALL have constant RX_ADDR, default 0, UART RX data register.
REQ-013 SHALL have constant TX_ADDR, default 4, UART TX data register.
REQ-014 SHALL have constant STATUS_ADDR, default 8, UART status register.
REQ-015 SHALL have constants RX_RDY_BIT, default 7, and TX_RDY_BIT, default 6, status ready flags.

Function
REQ-016 SHALL implement states S_QUERY_RX, S_READ, S_QUERY_TX, S_WRITE and S_CALC, plus a phase register with values KEY_N, KEY_D and DATA.
REQ-017 SHALL hold address and read/write stable while avm_waitrequest=1; a transfer completes in the cycle its request is high and avm_waitrequest=0, and the request SHALL drop the next cycle.
REQ-018 S_QUERY_RX SHALL read STATUS_ADDR; go to S_READ if readdata[RX_RDY_BIT]=1, else re-poll.
REQ-019 S_READ SHALL read RX_ADDR; on completion, the phase's 256-bit register shifts left 8 with readdata[7:0] into bits 7:0 (MSB byte first), and the byte counter increments.
REQ-020 On the 32nd byte, the byte counter SHALL wrap to 0: KEY_N->KEY_D, KEY_D->DATA, DATA->S_CALC with o_core_start=1 for exactly one cycle; otherwise return to S_QUERY_RX.
REQ-021 S_CALC SHALL latch i_core_result[255:0] into the output shift register only on a rising edge of i_core_finished; a level already high on entry is ignored; then go to S_QUERY_TX.
REQ-022 S_QUERY_TX SHALL read STATUS_ADDR; go to S_WRITE if readdata[TX_RDY_BIT]=1, else re-poll.
REQ-023 S_WRITE SHALL write bits 247:240 of the output register (MSB first) to TX_ADDR, then shift left 8; exactly 31 bytes are sent per block (result is below n, top byte dropped).
REQ-024 After the 31st byte, it SHALL return to S_QUERY_RX in phase DATA; the key persists and subsequent blocks reload only the ciphertext.
REQ-025 o_core_a/d/n SHALL be held constant from o_core_start until the latch in S_CALC.
REQ-026 avm_read and avm_write SHALL never be asserted simultaneously.
REQ-027 Throughput: per byte, at least one status read plus one data transfer, each a minimum of 1 cycle plus stalls; no pipelining.

Reset
REQ-028 On i_rst, it SHALL go to S_QUERY_RX with phase KEY_N, counters 0, and all data registers 0.
REQ-029 On i_rst, avm_read, avm_write and o_core_start SHALL be 0, avm_address SHALL be STATUS_ADDR, and avm_writedata SHALL be 0.
REQ-030 Reset mid-transfer SHALL abandon it; the next operation after reset is a key reload.

Structure
REQ-031 Package rsa_pkg SHALL hold the UART addresses, status bit indices, state and phase enums, and byte counts (32 RX, 31 TX).
REQ-032 The Avalon poll-then-transfer sequencing MAY be split into sub-module rsa_avm_byte_io; the core itself is instantiated outside this block.

Verification
REQ-033 Key n=33, d=7 and cipher 2 (each 32 bytes, zero-padded), with a behavioural core -> one start pulse, o_core_n=33, o_core_d=7, o_core_a=2; TX bytes are 30 x 0x00 followed by 0x1D.
REQ-034 avm_waitrequest held high 5 cycles on every access -> the same byte stream, request signals stable throughout each stall.
REQ-035 RX_RDY low for 20 polls before each byte -> no RX_ADDR read occurs while not ready; data is correct.
REQ-036 Two cipher blocks sent after one key -> two start pulses and 62 TX bytes; the key is not re-requested.
REQ-037 i_core_finished already high at start, then pulsed after 100 cycles -> the result is latched only on the later edge.
REQ-038 i_rst asserted after the 10th byte of d -> all outputs at reset values; a full n, d, cipher resend yields the correct result.
